// File: rtl/divider_pkg.sv
// Shared state encoding and width constants for the sequential 8/4 divider.
package divider_pkg;
  localparam int DVD_W = 8;
  localparam int DVS_W = 4;
  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/divider_trial_sub.sv
// 5-bit trial subtractor a - b as a + ~b + 1 on a generate/propagate carry chain.
module divider_trial_sub (
  input  logic [4:0] a,
  input  logic [4:0] b,
  output logic [4:0] diff,
  output logic       no_borrow
);
  logic [4:0] g, p;
  logic [5:0] c;

  assign g    = a & ~b;
  assign p    = a ^ ~b;
  assign c[0] = 1'b1;

  for (genvar i = 0; i < 5; i++) begin : g_carry
    assign c[i+1] = g[i] | (p[i] & c[i]);
  end

  assign diff      = p ^ c[4:0];
  // Carry out of a + ~b + 1 is set exactly when a >= b.
  assign no_borrow = c[5];
endmodule

// File: rtl/divider_8_by_4_seq.sv
// Restoring shift-subtract divider, 8-bit / 4-bit, one quotient bit per clock.
// Optional macro DIV_ZERO_DETECT_EN: a zero divisor skips RUN and flags div_by_zero.
module divider_8_by_4_seq
  import divider_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [DVD_W-1:0] quotient,
  output logic [DVS_W-1:0] remainder,
  output logic             div_by_zero
);
  state_t           state, nxt;
  logic [DVD_W-1:0] dvd_reg;
  logic [DVD_W-2:0] q_sr;
  logic [DVS_W-1:0] dvs_reg;
  logic [DVS_W:0]   prem, shifted, diff, prem_nxt;
  logic [CNT_W-1:0] cnt;
  logic             no_borrow, accept, zero_div, last, done_q;
  logic             unused_prem_msb;

  assign accept = start && (state != RUN);
  assign last   = (cnt == CNT_W'(DVD_W - 1));

`ifdef DIV_ZERO_DETECT_EN
  assign zero_div = (divisor == '0);
`else
  assign zero_div = 1'b0;
`endif

  // Dividend bits enter MSB first: cnt 0 selects bit 7, so index is 7 - cnt.
  assign shifted  = {prem[DVS_W-1:0], dvd_reg[~cnt]};
  assign prem_nxt = no_borrow ? diff : shifted;
  // prem stays below the divisor, so its top bit never feeds the next shift.
  assign unused_prem_msb = prem[DVS_W];

  divider_trial_sub u_trial (
    .a         (shifted),
    .b         ({1'b0, dvs_reg}),
    .diff      (diff),
    .no_borrow (no_borrow)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE, DONE: begin
        if (start) nxt = zero_div ? DONE : RUN;
        else       nxt = IDLE;
      end
      RUN:     if (last) nxt = DONE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_reg   <= '0;
      dvs_reg   <= '0;
      prem      <= '0;
      cnt       <= '0;
      q_sr      <= '0;
      quotient  <= '0;
      remainder <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= (state == DONE);
      if (accept) begin
        dvd_reg <= dividend;
        dvs_reg <= divisor;
        prem    <= '0;
        cnt     <= '0;
        q_sr    <= '0;
        if (zero_div) begin
          quotient  <= '1;
          remainder <= '0;
        end
      end else if (state == RUN) begin
        prem <= prem_nxt;
        cnt  <= cnt + 1'b1;
        q_sr <= {q_sr[DVD_W-3:0], no_borrow};
        // Results load only as RUN hands over to DONE.
        if (last) begin
          quotient  <= {q_sr, no_borrow};
          remainder <= prem_nxt[DVS_W-1:0];
        end
      end
    end
  end

`ifdef DIV_ZERO_DETECT_EN
  logic dbz_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     dbz_q <= 1'b0;
    else if (accept && zero_div)    dbz_q <= 1'b1;
    else if (state == RUN && last)  dbz_q <= 1'b0;
  end
  assign div_by_zero = dbz_q;
`else
  assign div_by_zero = 1'b0;
`endif

  assign busy = (state != IDLE);
  assign done = done_q;
endmodule
